// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared core-wide constants and types for the register write-back path.
//   XLEN       : integer datapath width
//   REG_ADDR_W : architectural register index width
//   NUM_REGS   : number of architectural integer registers
//   wb_t       : one registered write-stage beat (enable, origin, address, data)
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    logic      en;       // register-file write enable
    logic      is_load;  // beat originated from a load response
    reg_addr_t rd;
    xlen_t     data;
  } wb_t;

endpackage

// File: rtl/rd_tag_fifo.sv
// -----------------------------------------------------------------------------
// rd_tag_fifo
// Synchronous FIFO holding destination-register tags of outstanding loads, in
// issue order. Push while full and pop while empty are ignored.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i at the tail
//   data_i     : tag to push
//   pop_i      : drop the head entry
//   data_o     : current head tag (valid when !empty_o)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module rd_tag_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  reg_addr_t                data_i,
  input  logic                     pop_i,
  output reg_addr_t                data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  reg_addr_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reg_writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_writeback_scoreboard
// Merges single-cycle ALU results and in-order load returns into one registered
// register-file write stream, and tracks which registers await a load.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   alu_valid_i/rd/data: ALU result, always accepted, wins over load responses
//   ld_issue_i, ld_rd_i: load issue request and its destination
//   ld_issue_ready_o   : tag FIFO not full and ld_rd_i not already pending
//   ld_rsp_valid_i/data: load return data, in issue order
//   ld_rsp_ready_o     : high when no ALU result competes this cycle
//   rs1_i/rs2_i        : source registers queried by issue
//   rs1_busy_o/rs2_busy: register awaits a load (never for x0)
//   wr_en_o/rd_addr_o/wr_data_o : registered register-file write port
//   err_o              : sticky protocol error
// -----------------------------------------------------------------------------
module reg_writeback_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid_i,
  input  reg_addr_t  alu_rd_i,
  input  xlen_t      alu_data_i,
  input  logic       ld_issue_i,
  input  reg_addr_t  ld_rd_i,
  output logic       ld_issue_ready_o,
  input  logic       ld_rsp_valid_i,
  input  xlen_t      ld_rsp_data_i,
  output logic       ld_rsp_ready_o,
  input  reg_addr_t  rs1_i,
  input  reg_addr_t  rs2_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o,
  output logic       wr_en_o,
  output reg_addr_t  rd_addr_o,
  output xlen_t      wr_data_o,
  output logic       err_o
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_d;
  wb_t                 r_wb;
  wb_t                 w_wb_d;
  logic                r_err;
  logic                w_err_d;

  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  reg_addr_t                w_fifo_head;
  logic [$clog2(LD_DEPTH):0] w_unused_count;

  logic w_push;
  logic w_rsp_fire;
  logic w_pop;
  logic w_rsp_err;
  logic w_alu_hazard;

  assign ld_rsp_ready_o   = !alu_valid_i;
  assign ld_issue_ready_o = !w_fifo_full && !r_pending[ld_rd_i];

  assign w_push     = ld_issue_i && ld_issue_ready_o;
  assign w_rsp_fire = ld_rsp_valid_i && ld_rsp_ready_o;
  assign w_pop      = w_rsp_fire && !w_fifo_empty;
  assign w_rsp_err  = w_rsp_fire && w_fifo_empty;

  // ALU overwriting a register still owed by a load breaks in-order write-back.
  assign w_alu_hazard = alu_valid_i && (alu_rd_i != '0) && r_pending[alu_rd_i];

  assign rs1_busy_o = (rs1_i != '0) && r_pending[rs1_i];
  assign rs2_busy_o = (rs2_i != '0) && r_pending[rs2_i];

  rd_tag_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_rd_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  (ld_rd_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_unused_count)
  );

  // Write stage: address/data hold when idle, only the enable drops.
  always_comb begin
    w_wb_d         = r_wb;
    w_wb_d.en      = 1'b0;
    w_wb_d.is_load = 1'b0;
    if (alu_valid_i) begin
      w_wb_d.en   = (alu_rd_i != '0);
      w_wb_d.rd   = alu_rd_i;
      w_wb_d.data = alu_data_i;
    end else if (w_pop) begin
      w_wb_d.en      = (w_fifo_head != '0);
      w_wb_d.is_load = 1'b1;
      w_wb_d.rd      = w_fifo_head;
      w_wb_d.data    = ld_rsp_data_i;
    end
  end

  // Pending clears as the load beat commits, so busy drops once the register
  // file holds the value. Set and clear never target the same register since
  // issue is blocked while that register is pending.
  always_comb begin
    w_pending_d = r_pending;
    if (r_wb.en && r_wb.is_load) begin
      w_pending_d[r_wb.rd] = 1'b0;
    end
    if (w_push && (ld_rd_i != '0)) begin
      w_pending_d[ld_rd_i] = 1'b1;
    end
  end

  assign w_err_d = r_err || w_alu_hazard || w_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_wb      <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_d;
      r_wb      <= w_wb_d;
      r_err     <= w_err_d;
    end
  end

  assign wr_en_o   = r_wb.en;
  assign rd_addr_o = r_wb.rd;
  assign wr_data_o = r_wb.data;
  assign err_o     = r_err;

endmodule

// File: tb/tb_reg_writeback_scoreboard.sv
module tb_reg_writeback_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_issue_i;
  logic [4:0]  ld_rd_i;
  logic        ld_issue_ready_o;
  logic        ld_rsp_valid_i;
  logic [31:0] ld_rsp_data_i;
  logic        ld_rsp_ready_o;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wr_data_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  reg_writeback_scoreboard #(
    .LD_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_valid_i      (alu_valid_i),
    .alu_rd_i         (alu_rd_i),
    .alu_data_i       (alu_data_i),
    .ld_issue_i       (ld_issue_i),
    .ld_rd_i          (ld_rd_i),
    .ld_issue_ready_o (ld_issue_ready_o),
    .ld_rsp_valid_i   (ld_rsp_valid_i),
    .ld_rsp_data_i    (ld_rsp_data_i),
    .ld_rsp_ready_o   (ld_rsp_ready_o),
    .rs1_i            (rs1_i),
    .rs2_i            (rs2_i),
    .rs1_busy_o       (rs1_busy_o),
    .rs2_busy_o       (rs2_busy_o),
    .wr_en_o          (wr_en_o),
    .rd_addr_o        (rd_addr_o),
    .wr_data_o        (wr_data_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss;
    logic [4:0]  ld_rd;
    logic        rsp_v;
    logic [31:0] rsp_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_ready;
    logic        e_rsp_ready;
    logic        e_busy1;
    logic        e_busy2;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_r(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    alu_valid_i    = 1'b0;
    alu_rd_i       = '0;
    alu_data_i     = '0;
    ld_issue_i     = 1'b0;
    ld_rd_i        = '0;
    ld_rsp_valid_i = 1'b0;
    ld_rsp_data_i  = '0;
    rs1_i          = '0;
    rs2_i          = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string name, input logic [4:0] rd, input logic [31:0] data);
    chk_b({name, "_en"}, wr_en_o, 1'b1);
    chk_r({name, "_rd"}, rd_addr_o, rd);
    chk_d({name, "_data"}, wr_data_o, data);
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    chk_b("rst_wr_en", wr_en_o, 1'b0);
    chk_r("rst_rd", rd_addr_o, 5'd0);
    chk_d("rst_data", wr_data_o, 32'd0);
    chk_b("rst_err", err_o, 1'b0);
    rst_n = 1'b1;
  endtask

  // Reference model state
  logic [4:0]  q[$];
  logic [31:0] pend;
  logic        m_en;
  logic        m_ld;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_err;
  logic        e_ready;
  logic [4:0]  ar;
  logic [4:0]  head;

  initial begin
    set_idle();
    rst_n = 1'b0;
    #2;
    apply_reset();

    // Directed table: ALU write, load round trip, ALU/load conflict, busy release
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd0,  5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'h0,    5'd0,  5'd0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd0,  5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b0, 32'h0,    5'd7,  5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd7,  5'd5,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b1, 32'h1234, 5'd7,  5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h1234};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd7,  5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,    5'd7,  5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 1'b0, 32'h0,    5'd0,  5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[9]  = '{1'b1, 5'd3, 32'hA5A5,     1'b0, 5'd0,  1'b1, 32'h77,   5'd10, 5'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'hA5A5};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b1, 32'h77,   5'd10, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h77};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd10, 1'b0, 32'h0,    5'd10, 5'd10,
                 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd10, 1'b0, 32'h0,    5'd10, 5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};

    for (int i = 0; i < 13; i++) begin
      alu_valid_i    = vecs[i].alu_v;
      alu_rd_i       = vecs[i].alu_rd;
      alu_data_i     = vecs[i].alu_data;
      ld_issue_i     = vecs[i].iss;
      ld_rd_i        = vecs[i].ld_rd;
      ld_rsp_valid_i = vecs[i].rsp_v;
      ld_rsp_data_i  = vecs[i].rsp_data;
      rs1_i          = vecs[i].rs1;
      rs2_i          = vecs[i].rs2;
      #1;
      chk_b($sformatf("vec%0d_issue_ready", i), ld_issue_ready_o, vecs[i].e_ready);
      chk_b($sformatf("vec%0d_rsp_ready", i), ld_rsp_ready_o, vecs[i].e_rsp_ready);
      chk_b($sformatf("vec%0d_busy1", i), rs1_busy_o, vecs[i].e_busy1);
      chk_b($sformatf("vec%0d_busy2", i), rs2_busy_o, vecs[i].e_busy2);
      tick();
      chk_b($sformatf("vec%0d_wr_en", i), wr_en_o, vecs[i].e_en);
      if (vecs[i].e_en) begin
        chk_r($sformatf("vec%0d_rd", i), rd_addr_o, vecs[i].e_rd);
        chk_d($sformatf("vec%0d_data", i), wr_data_o, vecs[i].e_data);
      end
      chk_b($sformatf("vec%0d_err", i), err_o, 1'b0);
    end
    set_idle();

    // Full FIFO: four issues, a fifth is refused, responses drain in order
    for (int i = 1; i <= 4; i++) begin
      ld_issue_i = 1'b1;
      ld_rd_i    = 5'(i);
      #1;
      chk_b($sformatf("fill%0d_ready", i), ld_issue_ready_o, 1'b1);
      tick();
    end
    ld_rd_i = 5'd5;
    rs1_i   = 5'd4;
    #1;
    chk_b("full_ready", ld_issue_ready_o, 1'b0);
    chk_b("full_busy4", rs1_busy_o, 1'b1);
    tick();
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      ld_rsp_valid_i = 1'b1;
      ld_rsp_data_i  = 32'h100 + 32'(i);
      tick();
      check_write($sformatf("drain%0d", i), 5'(i), 32'h100 + 32'(i));
    end
    set_idle();
    tick();
    chk_b("drain_no_err", err_o, 1'b0);
    // Refused fifth issue must not have been queued: this response is orphaned
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 32'hBAD;
    tick();
    chk_b("orphan_wr_en", wr_en_o, 1'b0);
    chk_b("orphan_err", err_o, 1'b1);
    set_idle();
    tick();
    chk_b("err_sticky", err_o, 1'b1);
    apply_reset();

    // WAW stall and x0 loads
    ld_issue_i = 1'b1;
    ld_rd_i    = 5'd9;
    tick();
    rs2_i = 5'd9;
    #1;
    chk_b("waw_ready", ld_issue_ready_o, 1'b0);
    chk_b("waw_busy", rs2_busy_o, 1'b1);
    tick();
    ld_rd_i = 5'd0;
    rs1_i   = 5'd0;
    #1;
    chk_b("x0_ready", ld_issue_ready_o, 1'b1);
    tick();
    set_idle();
    #1;
    chk_b("x0_not_busy", rs1_busy_o, 1'b0);
    ld_rsp_valid_i = 1'b1;
    ld_rsp_data_i  = 32'h99;
    tick();
    check_write("waw_load", 5'd9, 32'h99);
    ld_rsp_data_i = 32'h55;
    tick();
    chk_b("x0_load_wr_en", wr_en_o, 1'b0);
    chk_b("x0_load_err", err_o, 1'b0);
    tick();
    chk_b("waw_second_not_queued", err_o, 1'b1);
    apply_reset();

    // ALU writing a register still owed by a load
    ld_issue_i = 1'b1;
    ld_rd_i    = 5'd20;
    tick();
    set_idle();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd20;
    alu_data_i  = 32'h42;
    tick();
    chk_b("alu_hazard_err", err_o, 1'b1);
    apply_reset();

    // Asynchronous reset in flight
    ld_issue_i = 1'b1;
    ld_rd_i    = 5'd12;
    tick();
    ld_rd_i = 5'd13;
    tick();
    set_idle();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd14;
    alu_data_i  = 32'hFFFF_0000;
    rs1_i       = 5'd12;
    #1;
    chk_b("pre_rst_busy", rs1_busy_o, 1'b1);
    tick();
    set_idle();
    rs1_i = 5'd12;
    ld_rd_i = 5'd12;
    rst_n = 1'b0;
    #1;
    chk_b("async_rst_busy", rs1_busy_o, 1'b0);
    chk_b("async_rst_ready", ld_issue_ready_o, 1'b1);
    chk_b("async_rst_wr_en", wr_en_o, 1'b0);
    chk_r("async_rst_rd", rd_addr_o, 5'd0);
    chk_d("async_rst_data", wr_data_o, 32'd0);
    tick();
    rst_n = 1'b1;
    ld_rsp_valid_i = 1'b1;
    tick();
    chk_b("rst_flushed_wr_en", wr_en_o, 1'b0);
    chk_b("rst_flushed_err", err_o, 1'b1);
    apply_reset();

    // Randomised traffic against a queue-based model
    q.delete();
    pend   = '0;
    m_en   = 1'b0;
    m_ld   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_err  = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      alu_valid_i = ($urandom_range(0, 3) == 0);
      ar = 5'($urandom_range(0, 31));
      if (pend[ar]) ar = 5'd0;
      alu_rd_i       = ar;
      alu_data_i     = $urandom();
      ld_issue_i     = ($urandom_range(0, 2) == 0);
      ld_rd_i        = 5'($urandom_range(0, 7));
      ld_rsp_valid_i = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      ld_rsp_data_i  = $urandom();
      rs1_i          = 5'($urandom_range(0, 7));
      rs2_i          = 5'($urandom_range(0, 7));
      e_ready = (q.size() < 4) && !pend[ld_rd_i];
      #1;
      chk_b("rnd_issue_ready", ld_issue_ready_o, e_ready);
      chk_b("rnd_rsp_ready", ld_rsp_ready_o, !alu_valid_i);
      chk_b("rnd_busy1", rs1_busy_o, (rs1_i != 0) && pend[rs1_i]);
      chk_b("rnd_busy2", rs2_busy_o, (rs2_i != 0) && pend[rs2_i]);

      if (alu_valid_i && (alu_rd_i != 0) && pend[alu_rd_i]) m_err = 1'b1;
      if (m_en && m_ld) pend[m_rd] = 1'b0;
      if (alu_valid_i) begin
        m_en = (alu_rd_i != 0); m_ld = 1'b0; m_rd = alu_rd_i; m_data = alu_data_i;
      end else if (ld_rsp_valid_i && q.size() != 0) begin
        head = q.pop_front();
        m_en = (head != 0); m_ld = 1'b1; m_rd = head; m_data = ld_rsp_data_i;
      end else begin
        if (ld_rsp_valid_i) m_err = 1'b1;
        m_en = 1'b0; m_ld = 1'b0;
      end
      if (ld_issue_i && e_ready) begin
        q.push_back(ld_rd_i);
        if (ld_rd_i != 0) pend[ld_rd_i] = 1'b1;
      end

      tick();
      chk_b("rnd_wr_en", wr_en_o, m_en);
      if (m_en) begin
        chk_r("rnd_rd", rd_addr_o, m_rd);
        chk_d("rnd_data", wr_data_o, m_data);
      end
      chk_b("rnd_err", err_o, m_err);
    end
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
